// File: rtl/pow2_scaler_pkg.sv
// Shared types and encodings for the pow2_scaler sequential shifter.
// Imported by the top level and by the single-step datapath.
package pow2_scaler_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam logic OP_DIV = 1'b0;
    localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/pow2_shift_step.sv
// One combinational scaling step: signed divide-by-2 truncating toward zero,
// or saturating multiply-by-2 with a saturation flag.
module pow2_shift_step
    import pow2_scaler_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic signed [N+1:0] acc_i,
    input  logic                sel_i,
    output logic signed [N+1:0] next_acc_o,
    output logic                sat_o
);

    logic signed [N+1:0] biased;

    always_comb begin
        // Adding 1 to negative values before the arithmetic shift rounds toward zero.
        biased     = acc_i + {{(N+1){1'b0}}, acc_i[N+1]};
        next_acc_o = acc_i;
        sat_o      = 1'b0;
        if (sel_i == OP_MUL) begin
            // Doubling overflows exactly when the two top bits differ.
            if (acc_i[N+1] != acc_i[N]) begin
                sat_o      = 1'b1;
                next_acc_o = acc_i[N+1] ? {1'b1, {(N+1){1'b0}}} : {1'b0, {(N+1){1'b1}}};
            end else begin
                next_acc_o = {acc_i[N:0], 1'b0};
            end
        end else begin
            next_acc_o = biased >>> 1;
        end
    end

endmodule

// File: rtl/pow2_scaler.sv
// Multi-cycle signed scaler by 2^k: one shift per clock, start/ready/valid handshake,
// registered result and sticky saturation flag.
module pow2_scaler
    import pow2_scaler_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned MAX_SHIFT = 7,
    parameter int unsigned SHW       = $clog2(MAX_SHIFT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [N:0]   a,
    input  logic                sel,
    input  logic [SHW-1:0]      shamt,
    output logic                ready,
    output logic                valid,
    output logic signed [N+1:0] result,
    output logic                overflow
);

    localparam logic [SHW-1:0] MaxCnt = SHW'(MAX_SHIFT);

    state_e              state_q, state_d;
    logic signed [N+1:0] acc_q, acc_d;
    logic signed [N+1:0] step_acc;
    logic                step_sat;
    logic [SHW-1:0]      cnt_q, cnt_d;
    logic                sel_q, sel_d;
    logic                ovf_q, ovf_d;
    logic signed [N+1:0] result_q, result_d;
    logic                overflow_q, overflow_d;
    logic                valid_q, valid_d;

    pow2_shift_step #(
        .N (N)
    ) u_step (
        .acc_i      (acc_q),
        .sel_i      (sel_q),
        .next_acc_o (step_acc),
        .sat_o      (step_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (cnt_q == '0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready    = (state_q == StIdle);
        valid    = valid_q;
        result   = result_q;
        overflow = overflow_q;
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        if (state_q == StIdle) begin
            if (start) begin
                acc_d = {a[N], a};
                cnt_d = (shamt > MaxCnt) ? MaxCnt : shamt;
                sel_d = sel;
                ovf_d = 1'b0;
            end
        end else if (cnt_q == '0) begin
            result_d   = acc_q;
            overflow_d = ovf_q;
            valid_d    = 1'b1;
        end else begin
            acc_d = step_acc;
            cnt_d = cnt_q - SHW'(1);
            ovf_d = ovf_q | step_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            sel_q      <= OP_DIV;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_pow2_scaler.sv
// Scoreboard bench for pow2_scaler: expected results are queued at issue time
// and compared when valid appears.
module tb_pow2_scaler;

    localparam int N         = 4;
    localparam int MAX_SHIFT = 7;
    localparam int SHW       = 3;
    localparam int HI        = (1 << (N + 1)) - 1;
    localparam int LO        = -(1 << (N + 1));

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic signed [N:0]   a;
    logic                sel;
    logic [SHW-1:0]      shamt;
    logic                ready;
    logic                valid;
    logic signed [N+1:0] result;
    logic                overflow;

    typedef struct {
        int res;
        bit ovf;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pow2_scaler #(
        .N         (N),
        .MAX_SHIFT (MAX_SHIFT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .sel      (sel),
        .shamt    (shamt),
        .ready    (ready),
        .valid    (valid),
        .result   (result),
        .overflow (overflow)
    );

    function automatic exp_t model(input int av, input bit s, input int k);
        exp_t e;
        int   kk;
        int   v;
        kk    = (k > MAX_SHIFT) ? MAX_SHIFT : k;
        e.ovf = 1'b0;
        if (s) begin
            v = av;
            for (int i = 0; i < kk; i++) begin
                v = v * 2;
                if (v > HI) begin
                    v     = HI;
                    e.ovf = 1'b1;
                end else if (v < LO) begin
                    v     = LO;
                    e.ovf = 1'b1;
                end
            end
        end else begin
            v = av / (1 << kk);
        end
        e.res = v;
        e.lat = kk + 1;
        return e;
    endfunction

    // Called just after an edge; returns just after the acceptance edge.
    task automatic issue(input int av, input bit s, input int k, input bit track);
        a     = av[N:0];
        sel   = s;
        shamt = k[SHW-1:0];
        start = 1'b1;
        if (track) sb.push_back(model(av, s, k));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int already, output int lat, output bit timeout);
        int edges;
        edges   = already;
        timeout = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (valid) begin
                timeout = 1'b0;
                break;
            end
        end
        lat = edges;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        sel   = 1'b0;
        shamt = '0;
        #23;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", ready);
        end
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", valid);
        end
        checks++;
        if (result !== '0) begin
            failures++;
            $display("FAIL reset_result got=%0d want=0", result);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_overflow got=%b want=0", overflow);
        end
    endtask

    task automatic test_multiply;
        int                  av[5] = '{5, -16, 15, -16, 1};
        int                  ks[5] = '{2, 1, 2, 2, 7};
        int                  lat;
        bit                  to;
        exp_t                e;
        logic signed [N+1:0] er;
        for (int i = 0; i < 5; i++) begin
            issue(av[i], 1'b1, ks[i], 1'b1);
            wait_valid(0, lat, to);
            e  = sb.pop_front();
            er = e.res[N+1:0];
            checks++;
            if (to) begin
                failures++;
                $display("FAIL mul_timeout[%0d] no valid within bound", i);
            end else begin
                checks++;
                if (result !== er) begin
                    failures++;
                    $display("FAIL mul_result[%0d] got=%0d want=%0d", i, result, er);
                end
                checks++;
                if (overflow !== e.ovf) begin
                    failures++;
                    $display("FAIL mul_overflow[%0d] got=%b want=%b", i, overflow, e.ovf);
                end
                checks++;
                if (lat != e.lat) begin
                    failures++;
                    $display("FAIL mul_latency[%0d] got=%0d want=%0d", i, lat, e.lat);
                end
            end
        end
    endtask

    task automatic test_divide;
        int                  av[5] = '{-7, -7, 7, -15, -16};
        int                  ks[5] = '{1, 2, 3, 7, MAX_SHIFT};
        int                  lat;
        bit                  to;
        exp_t                e;
        logic signed [N+1:0] er;
        for (int i = 0; i < 5; i++) begin
            issue(av[i], 1'b0, ks[i], 1'b1);
            wait_valid(0, lat, to);
            e  = sb.pop_front();
            er = e.res[N+1:0];
            checks++;
            if (to) begin
                failures++;
                $display("FAIL div_timeout[%0d] no valid within bound", i);
            end else begin
                checks++;
                if (result !== er) begin
                    failures++;
                    $display("FAIL div_result[%0d] got=%0d want=%0d", i, result, er);
                end
                checks++;
                if (overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL div_overflow[%0d] got=%b want=0", i, overflow);
                end
                checks++;
                if (lat != e.lat) begin
                    failures++;
                    $display("FAIL div_latency[%0d] got=%0d want=%0d", i, lat, e.lat);
                end
            end
        end
    endtask

    task automatic test_handshake;
        int                  lat;
        bit                  to;
        exp_t                e;
        logic signed [N+1:0] er;
        logic signed [N+1:0] held;
        // k=0: single-cycle latency.
        issue(-9, 1'b1, 0, 1'b1);
        wait_valid(0, lat, to);
        e  = sb.pop_front();
        er = e.res[N+1:0];
        checks++;
        if (to || result !== er || lat != 1) begin
            failures++;
            $display("FAIL k0 got=%0d lat=%0d want=%0d lat=1", result, lat, er);
        end
        held = result;
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0 || result !== held) begin
            failures++;
            $display("FAIL valid_pulse valid=%b result=%0d want valid=0 result=%0d",
                     valid, result, held);
        end
        // Start toggled during RUN must be ignored.
        issue(-13, 1'b0, 3, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL run_ready got=%b want=0", ready);
        end
        start = 1'b1;
        a     = 5'sd9;
        sel   = 1'b1;
        shamt = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        wait_valid(3, lat, to);
        e  = sb.pop_front();
        er = e.res[N+1:0];
        checks++;
        if (to || result !== er || overflow !== e.ovf || lat != e.lat) begin
            failures++;
            $display("FAIL ignore_start got=%0d ovf=%b lat=%0d want=%0d ovf=%b lat=%0d",
                     result, overflow, lat, er, e.ovf, e.lat);
        end
    endtask

    task automatic test_back_to_back;
        int                  lat;
        bit                  to;
        exp_t                e;
        logic signed [N+1:0] er;
        issue(3, 1'b1, 1, 1'b1);
        wait_valid(0, lat, to);
        e  = sb.pop_front();
        er = e.res[N+1:0];
        checks++;
        if (to || result !== er || ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first got=%0d ready=%b want=%0d ready=1", result, ready, er);
        end
        issue(-7, 1'b0, 2, 1'b1);
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept ready=%b want=0", ready);
        end
        wait_valid(0, lat, to);
        e  = sb.pop_front();
        er = e.res[N+1:0];
        checks++;
        if (to || result !== er || lat != e.lat) begin
            failures++;
            $display("FAIL b2b_second got=%0d lat=%0d want=%0d lat=%0d", result, lat, er, e.lat);
        end
    endtask

    task automatic test_overflow_clear;
        int                  av[2] = '{15, 3};
        int                  ks[2] = '{2, 1};
        int                  lat;
        bit                  to;
        exp_t                e;
        logic signed [N+1:0] er;
        for (int i = 0; i < 2; i++) begin
            issue(av[i], 1'b1, ks[i], 1'b1);
            wait_valid(0, lat, to);
            e  = sb.pop_front();
            er = e.res[N+1:0];
            checks++;
            if (to || result !== er || overflow !== e.ovf) begin
                failures++;
                $display("FAIL ovf_clear[%0d] got=%0d ovf=%b want=%0d ovf=%b",
                         i, result, overflow, er, e.ovf);
            end
        end
    endtask

    task automatic test_reset_abort;
        int                  lat;
        bit                  to;
        bit                  seen;
        exp_t                e;
        logic signed [N+1:0] er;
        issue(15, 1'b1, 2, 1'b1);
        wait_valid(0, lat, to);
        e  = sb.pop_front();
        er = e.res[N+1:0];
        checks++;
        if (to || result !== er || overflow !== e.ovf) begin
            failures++;
            $display("FAIL abort_pre got=%0d ovf=%b want=%0d ovf=%b", result, overflow, er, e.ovf);
        end
        issue(5, 1'b1, 3, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_ctrl ready=%b valid=%b want ready=1 valid=0", ready, valid);
        end
        checks++;
        if (result !== '0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL abort_out result=%0d ovf=%b want 0 0", result, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL abort_no_valid got valid after abort want none");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_handshake();
        test_back_to_back();
        test_overflow_clear();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
